mul_product_accumulator: RTL and testbench
==========================================

# mul_product_accumulator

Downstream consumer of the 16x16 sequential multiplier's 32-bit product. Accepts one unsigned product per valid/ready handshake and sums the products of one group into a wide saturating accumulator. A group ends on the product tagged `in_last` or on the MAX_TERMS-th product. The block then presents the group sum, term count and status on a held valid/ready output and clears itself for the next group.

## Interface
Parameters:
- PROD_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator width; must be greater than PROD_W.
- MAX_TERMS, 16, maximum products per group; must be 2 or more.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter (derived).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- in_valid  in  1  product available.
- in_ready  out  1  block can accept a product this cycle.
- in_product  in  PROD_W  unsigned product.
- in_last  in  1  final product of the group; sampled only on handshake.
- out_valid  out  1  group result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  group sum, saturated.
- out_count  out  CNT_W  number of products in the group.
- out_sat  out  1  sum clipped at all-ones during this group (sticky).
- out_forced  out  1  group ended on MAX_TERMS with no in_last.

## Operation
- FSM has two states:
  - ACCUM: reset state; in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input handshake is in_valid && in_ready at a rising edge.
- Accumulate (ACCUM state, on input handshake):
  - sum computed ACC_W+1 bits wide: acc + zero-extended in_product.
  - If bit ACC_W is set: acc <= all-ones, sat <= 1. Otherwise acc <= sum[ACC_W-1:0].
  - cnt <= cnt + 1.
- Group termination, on an input handshake:
  - If in_last=1, or cnt+1 == MAX_TERMS: go to HOLD.
  - forced <= (in_last==0) on this handshake.
  - The terminating product is included in out_sum and out_count.
- Output in HOLD:
  - out_sum=acc, out_count=cnt, out_sat=sat, out_forced=forced.
  - All outputs stay stable until the output handshake.
- Output handshake (out_valid && out_ready):
  - acc, cnt, sat, forced <= 0.
  - state <= ACCUM.
- In ACCUM, out_sum/out_count/out_sat/out_forced show the live running values. Consumers use them only while out_valid=1.
- Once the group has saturated, acc stays all-ones and cnt keeps counting.
- Never adds a product while in HOLD; input stalls via in_ready=0.
- Reset mid-group or mid-HOLD: the partial group is discarded and outputs return to reset values.
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_sat=0, out_forced=0. Internal: state=ACCUM, acc=0, cnt=0.

## Timing
- in_ready and out_valid are decoded directly from the state register; no combinational path from any input.
- Latency: a terminating handshake at edge k gives out_valid=1 from just after edge k.
- Minimum output hold is one cycle: out_ready=1 on the first HOLD cycle gives in_ready=1 just after edge k+1.
- Throughput:
  - One product per cycle within a group.
  - One bubble cycle per group (the HOLD cycle).
  - Minimum spacing is 2 cycles per single-term group.
- in_product and in_last are ignored when the handshake does not occur.
- Back-pressure: HOLD is held indefinitely while out_ready=0.
- out_ready while out_valid=0 has no effect.
- Reset assertion takes effect immediately (asynchronous). Deassertion is expected synchronous to clk, provided externally.

## Test plan
- Single group: products 6, 10, 300 with last on 300 -> out_valid one cycle after the 300 handshake; out_sum=316, out_count=3, out_sat=0, out_forced=0.
- Single-term group: one product 0xFFFE0001 with last=1 -> out_sum=0xFFFE0001, out_count=1.
  - With out_ready held 1: in_ready=0 for exactly one cycle, then the next group accepts.
- Forced end: 16 products of 1, last=0 -> out_count=16, out_sum=16, out_forced=1.
  - The 17th product is stalled while in HOLD, then becomes term 1 of a new group.
- Saturation: ACC_W=40, 16 products of 0xFFFFFFFF -> no saturation, out_sum=0xF_FFFF_FFF0, out_sat=0.
  - Same run with ACC_W=33 -> out_sum=0x1_FFFF_FFFF, out_sat=1.
- Back-pressure: out_ready=0 for 10 cycles in HOLD with in_valid=1 throughout.
  - Required: outputs stable, in_ready=0, no product absorbed.
  - On release, the pending product is accepted the cycle after the output handshake.
- Reset mid-group: after products 5 and 7, pull reset low for 1 cycle mid-clock.
  - Required: immediate outputs 0.
  - A new group of 9 (last) then gives out_sum=9, out_count=1.

Source files
------------

// File: rtl/mul_product_accumulator_if.sv
// mul_product_accumulator_if: product input stream and group-result output stream.
interface mul_product_accumulator_if #(
   parameter int PROD_W = 32,
   parameter int ACC_W = 40,
   parameter int CNT_W = 5
);
   logic in_valid, in_ready, in_last;
   logic [PROD_W-1:0] in_product;
   logic out_valid, out_ready, out_sat, out_forced;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   modport master (
      output in_valid, in_product, in_last, out_ready,
      input in_ready, out_valid, out_sum, out_count, out_sat, out_forced
   );
   modport slave (
      input in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_sat, out_forced
   );
endinterface

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator: sums groups of unsigned products into a saturating accumulator.
module mul_product_accumulator #(
   parameter int PROD_W = 32,
   parameter int ACC_W = 40,
   parameter int MAX_TERMS = 16,
   parameter int CNT_W = $clog2(MAX_TERMS + 1)
) (
   input logic clk,
   input logic reset,
   mul_product_accumulator_if.slave bus
);
   typedef enum logic {ACCUM, HOLD} state_t;
   state_t state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic sat, forced;
   logic [ACC_W:0] sum;
   assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= ACCUM;
         acc <= '0;
         cnt <= '0;
         sat <= 1'b0;
         forced <= 1'b0;
      end else if (state == ACCUM && bus.in_valid) begin
         acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
         sat <= sat | sum[ACC_W];
         cnt <= cnt + 1'b1;
         if (bus.in_last || cnt == CNT_W'(MAX_TERMS - 1)) begin
            state <= HOLD;
            forced <= !bus.in_last;
         end
      end else if (state == HOLD && bus.out_ready) begin
         state <= ACCUM;
         acc <= '0;
         cnt <= '0;
         sat <= 1'b0;
         forced <= 1'b0;
      end
   assign bus.in_ready = state == ACCUM;
   assign bus.out_valid = state == HOLD;
   assign bus.out_sum = acc;
   assign bus.out_count = cnt;
   assign bus.out_sat = sat;
   assign bus.out_forced = forced;
endmodule

// File: tb/tb_mul_product_accumulator.sv
// tb_mul_product_accumulator: directed and random groups checked against an arithmetic model.
module tb_mul_product_accumulator;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int tests = 0;
   int fails = 0;
   longint unsigned tot;
   int cnt;
   bit hold, forced;
   localparam longint unsigned M40 = 64'hFF_FFFF_FFFF;
   localparam longint unsigned M33 = 64'h1_FFFF_FFFF;
   always #5 clk = ~clk;
   mul_product_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(5)) bus ();
   mul_product_accumulator_if #(.PROD_W(32), .ACC_W(33), .CNT_W(5)) b33 ();
   assign b33.in_valid = bus.in_valid;
   assign b33.in_product = bus.in_product;
   assign b33.in_last = bus.in_last;
   assign b33.out_ready = bus.out_ready;
   mul_product_accumulator #(.PROD_W(32), .ACC_W(40), .MAX_TERMS(16)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
   mul_product_accumulator #(.PROD_W(32), .ACC_W(33), .MAX_TERMS(16)) dut33 (
      .clk(clk), .reset(reset), .bus(b33.slave));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic clear_model();
      tot = 0;
      cnt = 0;
      hold = 0;
      forced = 0;
   endtask
   task automatic push(input logic [31:0] p, input logic l);
      chk("in_ready_before_push", bus.in_ready, 1);
      bus.in_valid = 1;
      bus.in_product = p;
      bus.in_last = l;
      @(posedge clk); #1;
      bus.in_valid = 0;
      bus.in_product = $urandom;
      bus.in_last = $urandom;
      tot += p;
      cnt++;
      if (l || cnt == 16) begin
         hold = 1;
         forced = !l;
      end
      chk("out_valid_after_push", bus.out_valid, hold);
   endtask
   task automatic check_result();
      chk("out_valid", bus.out_valid, 1);
      chk("in_ready_hold", bus.in_ready, 0);
      chk("sum40", bus.out_sum, tot > M40 ? M40 : tot);
      chk("count", bus.out_count, cnt);
      chk("sat40", bus.out_sat, tot > M40);
      chk("forced", bus.out_forced, forced);
      chk("sum33", b33.out_sum, tot > M33 ? M33 : tot);
      chk("sat33", b33.out_sat, tot > M33);
      chk("count33", b33.out_count, cnt);
   endtask
   task automatic drain(input int n);
      repeat (n) begin
         bus.in_valid = 1;
         bus.in_product = $urandom;
         bus.in_last = $urandom;
         @(posedge clk); #1;
         check_result();
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      @(posedge clk); #1;
      bus.out_ready = 0;
      clear_model();
      chk("out_valid_cleared", bus.out_valid, 0);
      chk("in_ready_restored", bus.in_ready, 1);
      chk("count_cleared", bus.out_count, 0);
      chk("sum_cleared", bus.out_sum, 0);
      chk("forced_cleared", bus.out_forced, 0);
   endtask
   initial begin
      bus.in_valid = 0;
      bus.in_product = 0;
      bus.in_last = 0;
      bus.out_ready = 0;
      clear_model();
      repeat (2) @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum", bus.out_sum, 0);
      chk("rst_count", bus.out_count, 0);
      chk("rst_sat", bus.out_sat, 0);
      chk("rst_forced", bus.out_forced, 0);
      reset = 1;
      @(posedge clk); #1;
      push(6, 0);
      push(10, 0);
      push(300, 1);
      check_result();
      chk("group1_sum", bus.out_sum, 316);
      drain(0);
      push(32'hFFFE0001, 1);
      check_result();
      drain(0);
      push(3, 1);
      check_result();
      drain(1);
      for (int i = 0; i < 16; i++) push(1, 0);
      check_result();
      chk("forced_sum", bus.out_sum, 16);
      bus.in_valid = 1;
      bus.in_product = 32'h1234;
      bus.in_last = 0;
      repeat (10) begin
         @(posedge clk); #1;
         check_result();
      end
      bus.out_ready = 1;
      @(posedge clk); #1;
      bus.out_ready = 0;
      clear_model();
      chk("bp_released", bus.out_valid, 0);
      chk("bp_not_absorbed", bus.out_count, 0);
      @(posedge clk); #1;
      bus.in_valid = 0;
      tot = 32'h1234;
      cnt = 1;
      chk("pending_count", bus.out_count, 1);
      chk("pending_sum", bus.out_sum, 32'h1234);
      push(2, 1);
      check_result();
      drain(0);
      for (int i = 0; i < 16; i++) push(32'hFFFFFFFF, 0);
      check_result();
      chk("sat_sum40", bus.out_sum, 64'hF_FFFF_FFF0);
      chk("sat_sum33", b33.out_sum, M33);
      chk("sat_flag33", b33.out_sat, 1);
      drain(2);
      push(5, 0);
      push(7, 0);
      #3 reset = 0;
      #1;
      chk("mid_rst_sum", bus.out_sum, 0);
      chk("mid_rst_count", bus.out_count, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      #9 reset = 1;
      @(posedge clk); #1;
      clear_model();
      push(9, 1);
      check_result();
      chk("post_rst_sum", bus.out_sum, 9);
      drain(0);
      for (int g = 0; g < 40; g++) begin
         while (!hold) begin
            repeat ($urandom_range(0, 1)) begin
               bus.in_product = $urandom;
               bus.in_last = $urandom;
               @(posedge clk); #1;
            end
            push($urandom, $urandom_range(0, 4) == 0);
         end
         check_result();
         drain($urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
